melody_player: RTL
==================

MELODY_PLAYER -- requirements
Module: melody_player

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have parameter SPEED, default 4, meaning beats per second; BEAT_CYCLES = CLK_HZ/SPEED.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 1_250_000, meaning the articulation rest at the end of each note; legal range is 1..BEAT_CYCLES-1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port i_start, input, 1 bit: a one-cycle request to play the song selected by i_song_sel.
REQ-007 The block SHALL have port i_stop, input, 1 bit: a one-cycle request to abort playback.
REQ-008 The block SHALL have port i_song_sel, input, 2 bits: the song index, sampled only when i_start is accepted.
REQ-009 The block SHALL have port i_loop, input, 1 bit: when 1 at song end, playback restarts from entry 0; sampled at song end.
REQ-010 The block SHALL have port music_scale, output, 6 bits: the registered note code for the buzzer (0 = rest, 1..21 = C_LOW..B_HIGH).
REQ-011 The block SHALL have port o_busy, output, 1 bit: high in PLAY and GAP.
REQ-012 The block SHALL have port o_done, output, 1 bit: a one-cycle pulse when a non-looping song ends.
REQ-013 The block SHALL have port o_note_idx, output, 5 bits: the current entry index within the song.

Function
REQ-014 ROM entry format: 8 bits; [7:2] is the note code, [1:0] is dur; note length = (dur+1)*BEAT_CYCLES cycles.
REQ-015 ROM address = {song_sel_latched, note_idx}, giving 4 songs of 32 entries each; ROM read is combinational.
REQ-016 A note code of 63 SHALL be END_MARK, meaning the song ends with no sound; codes 22..62 SHALL drive music_scale = 0 for their full duration.
REQ-017 FSM states SHALL be IDLE, PLAY, GAP and DONE.
- IDLE -> PLAY on i_start.
- PLAY -> GAP after (dur+1)*BEAT_CYCLES - GAP_CYCLES cycles.
- GAP -> PLAY (next entry) after GAP_CYCLES cycles.
- DONE -> IDLE after 1 cycle.
REQ-018 If i_start is sampled at edge N, music_scale SHALL equal the entry-0 note from edge N+1, o_note_idx = 0, and the in-note cycle counter SHALL start at 0.
REQ-019 In GAP, music_scale SHALL be 0; in PLAY, music_scale SHALL be the current entry's note.
REQ-020 Song end occurs when the next entry is END_MARK or the current index is 31.
- i_loop=1: next state is PLAY with index 0; no o_done pulse.
- i_loop=0: DONE for 1 cycle with o_done=1, then IDLE.
REQ-021 If entry 0 is END_MARK, the block SHALL go IDLE -> DONE, and o_done SHALL assert at edge N+1.
REQ-022 i_stop in any state SHALL force IDLE at the next edge with music_scale=0, o_busy=0 and no o_done pulse; i_stop has priority over a simultaneous i_start.
REQ-023 i_start during PLAY or GAP SHALL restart from entry 0 with a newly latched i_song_sel.
REQ-024 music_scale, o_busy, o_done and o_note_idx SHALL all be registered outputs.

Reset
REQ-025 While rst_n=0, the following SHALL hold:
- state = IDLE
- music_scale = 0
- o_busy = 0
- o_done = 0
- o_note_idx = 0
- all counters = 0
- latched song_sel = 0
REQ-026 Reset asserted mid-song SHALL silence the output immediately and asynchronously; after release, the block SHALL wait in IDLE for i_start.

Structure
REQ-027 Shared package music_pkg SHALL hold:
- the note-code constants REST=0 .. B_HIGH=21
- END_MARK=63
- the FSM state typedef
- the ROM entry field widths
REQ-028 Song data SHALL reside in the sub-module melody_rom: a 128x8 combinational ROM with a 7-bit address in and 8-bit data out.

Verification (CLK_HZ=16, SPEED=4, so BEAT_CYCLES=4; GAP_CYCLES=1)
REQ-029 Song 1 = {8,dur0},{10,dur1},END; i_start at edge 0 -> music_scale = 8 at cycles 1-3, 0 at cycle 4, 10 at cycles 5-11, 0 at cycle 12; o_done=1 at cycle 13 only; o_busy=1 during cycles 1-12.
REQ-030 Same song with i_loop=1 -> music_scale = 8 again at cycles 13-15, o_note_idx returns to 0, and o_done is never asserted.
REQ-031 i_stop at cycle 6 -> music_scale=0 and o_busy=0 from cycle 7, with no o_done pulse; i_start and i_stop in the same cycle -> the block stays IDLE.
REQ-032 Song 2 with entry 0 = END_MARK; i_start at edge 0 -> o_done=1 at cycle 1, music_scale stays 0, and o_busy is never asserted.
REQ-033 rst_n low at cycle 6 of song 1 -> all outputs are 0 asynchronously; after release, the block stays IDLE until the next i_start.
REQ-034 Song 3 with 32 entries of {21,dur3} and no END_MARK -> the song ends after index 31 (cycle 513) with o_done=1.

Source files
------------

// File: rtl/music_pkg.sv
// Purpose : shared note codes, ROM entry layout and FSM state type for the melody player.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package music_pkg;

   // ROM entry layout: [7:2] note code, [1:0] duration in beats minus one
   localparam int NOTE_W  = 6;
   localparam int DUR_W   = 2;
   localparam int ENTRY_W = NOTE_W + DUR_W;
   localparam int IDX_W   = 5;
   localparam int SONG_W  = 2;
   localparam int ADDR_W  = SONG_W + IDX_W;

   localparam logic [NOTE_W-1:0] REST     = 6'd0;
   localparam logic [NOTE_W-1:0] C_LOW    = 6'd1;
   localparam logic [NOTE_W-1:0] D_LOW    = 6'd2;
   localparam logic [NOTE_W-1:0] E_LOW    = 6'd3;
   localparam logic [NOTE_W-1:0] F_LOW    = 6'd4;
   localparam logic [NOTE_W-1:0] G_LOW    = 6'd5;
   localparam logic [NOTE_W-1:0] A_LOW    = 6'd6;
   localparam logic [NOTE_W-1:0] B_LOW    = 6'd7;
   localparam logic [NOTE_W-1:0] C_MID    = 6'd8;
   localparam logic [NOTE_W-1:0] D_MID    = 6'd9;
   localparam logic [NOTE_W-1:0] E_MID    = 6'd10;
   localparam logic [NOTE_W-1:0] F_MID    = 6'd11;
   localparam logic [NOTE_W-1:0] G_MID    = 6'd12;
   localparam logic [NOTE_W-1:0] A_MID    = 6'd13;
   localparam logic [NOTE_W-1:0] B_MID    = 6'd14;
   localparam logic [NOTE_W-1:0] C_HIGH   = 6'd15;
   localparam logic [NOTE_W-1:0] D_HIGH   = 6'd16;
   localparam logic [NOTE_W-1:0] E_HIGH   = 6'd17;
   localparam logic [NOTE_W-1:0] F_HIGH   = 6'd18;
   localparam logic [NOTE_W-1:0] G_HIGH   = 6'd19;
   localparam logic [NOTE_W-1:0] A_HIGH   = 6'd20;
   localparam logic [NOTE_W-1:0] B_HIGH   = 6'd21;
   localparam logic [NOTE_W-1:0] END_MARK = 6'd63;

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP, S_DONE} state_t;

   function automatic logic [ENTRY_W-1:0] mk_entry(input logic [NOTE_W-1:0] note,
                                                   input logic [DUR_W-1:0]  dur);
      return {note, dur};
   endfunction

   // Codes above B_HIGH (other than END_MARK, which never reaches the buzzer) are silent
   function automatic logic [NOTE_W-1:0] drive_code(input logic [NOTE_W-1:0] code);
      return (code <= B_HIGH) ? code : REST;
   endfunction

endpackage

// File: rtl/melody_rom.sv
// Purpose : 128x8 song table, 4 songs of 32 entries, addressed {song, index}.
// Latency : combinational read.
// Backpressure: none.
// Ports   : addr_i [6:0] = {song, index}; data_o [7:0] = {note, dur}.
module melody_rom
   import music_pkg::*;
(
   input  logic [ADDR_W-1:0]  addr_i,
   output logic [ENTRY_W-1:0] data_o
);

   always_comb begin
      data_o = mk_entry(END_MARK, 2'd0);
      case (addr_i[ADDR_W-1:IDX_W])
         2'd0: begin
            case (addr_i[IDX_W-1:0])
               5'd0:    data_o = mk_entry(C_LOW, 2'd0);
               5'd1:    data_o = mk_entry(E_LOW, 2'd0);
               5'd2:    data_o = mk_entry(G_LOW, 2'd1);
               5'd3:    data_o = mk_entry(6'd30, 2'd0);   // out-of-range code: plays as silence
               5'd4:    data_o = mk_entry(C_MID, 2'd0);
               default: data_o = mk_entry(END_MARK, 2'd0);
            endcase
         end
         2'd1: begin
            case (addr_i[IDX_W-1:0])
               5'd0:    data_o = mk_entry(C_MID, 2'd0);
               5'd1:    data_o = mk_entry(E_MID, 2'd1);
               default: data_o = mk_entry(END_MARK, 2'd0);
            endcase
         end
         2'd2:    data_o = mk_entry(END_MARK, 2'd0);     // empty song
         default: data_o = mk_entry(B_HIGH, 2'd3);       // full 32 entries, no terminator
      endcase
   end

endmodule

// File: rtl/melody_player.sv
// Purpose : plays a ROM song on a buzzer note code, with per-note articulation gap and looping.
// Latency : i_start sampled at edge N -> first note on music_scale after edge N; all outputs registered.
// Backpressure: none; i_stop beats i_start, i_start restarts any playing song, start ignored during DONE.
// Ports   : clk, rst_n (async active-low), i_start, i_stop, i_song_sel[1:0], i_loop;
//           music_scale[5:0], o_busy, o_done (1-cycle pulse), o_note_idx[4:0].
module melody_player
   import music_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int SPEED      = 4,
   parameter int GAP_CYCLES = 1_250_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic [SONG_W-1:0] i_song_sel,
   input  logic              i_loop,
   output logic [NOTE_W-1:0] music_scale,
   output logic              o_busy,
   output logic              o_done,
   output logic [IDX_W-1:0]  o_note_idx
);

   localparam int BEAT_CYCLES = CLK_HZ / SPEED;
   localparam int CNT_W       = $clog2(4 * BEAT_CYCLES + 1);
   typedef logic [CNT_W-1:0] cnt_t;

   // Terminal count of the sounding part of a note, per duration code
   localparam cnt_t PLAY_LAST0 = cnt_t'(1 * BEAT_CYCLES - GAP_CYCLES - 1);
   localparam cnt_t PLAY_LAST1 = cnt_t'(2 * BEAT_CYCLES - GAP_CYCLES - 1);
   localparam cnt_t PLAY_LAST2 = cnt_t'(3 * BEAT_CYCLES - GAP_CYCLES - 1);
   localparam cnt_t PLAY_LAST3 = cnt_t'(4 * BEAT_CYCLES - GAP_CYCLES - 1);
   localparam cnt_t GAP_LAST   = cnt_t'(GAP_CYCLES - 1);

   state_t              state_q;
   logic [SONG_W-1:0]   song_q;
   logic [IDX_W-1:0]    idx_q;
   cnt_t                cnt_q;
   logic [DUR_W-1:0]    dur_q;
   logic                end_q;      // current entry is the last one of the song

   logic [ADDR_W-1:0]   rom_addr_d;
   logic [ENTRY_W-1:0]  rom_data;
   logic [NOTE_W-1:0]   rom_note;
   logic [DUR_W-1:0]    rom_dur;
   logic [IDX_W-1:0]    idx_inc_d;
   logic                start_acc_d;
   cnt_t                play_last_d;

   assign rom_note    = rom_data[ENTRY_W-1:DUR_W];
   assign rom_dur     = rom_data[DUR_W-1:0];
   assign idx_inc_d   = idx_q + 5'd1;
   assign start_acc_d = i_start && !i_stop && (state_q != S_DONE);

   // One ROM port serves three readers: entry 0 of the new song on start,
   // the following entry while playing (end lookahead) and during the gap
   // (next note), or entry 0 again when the gap ends a looping song.
   always_comb begin
      rom_addr_d = {song_q, idx_inc_d};
      if (start_acc_d)
         rom_addr_d = {i_song_sel, 5'd0};
      else if (state_q == S_GAP && end_q)
         rom_addr_d = {song_q, 5'd0};
   end

   always_comb begin
      case (dur_q)
         2'd0:    play_last_d = PLAY_LAST0;
         2'd1:    play_last_d = PLAY_LAST1;
         2'd2:    play_last_d = PLAY_LAST2;
         default: play_last_d = PLAY_LAST3;
      endcase
   end

   melody_rom u_rom (
      .addr_i (rom_addr_d),
      .data_o (rom_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         song_q      <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         dur_q       <= '0;
         end_q       <= 1'b0;
         music_scale <= REST;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_note_idx  <= '0;
      end else if (i_stop) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         end_q       <= 1'b0;
         music_scale <= REST;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_note_idx  <= '0;
      end else if (start_acc_d) begin
         song_q     <= i_song_sel;
         idx_q      <= '0;
         o_note_idx <= '0;
         cnt_q      <= '0;
         end_q      <= 1'b0;
         dur_q      <= rom_dur;
         if (rom_note == END_MARK) begin
            state_q     <= S_DONE;
            music_scale <= REST;
            o_busy      <= 1'b0;
            o_done      <= 1'b1;
         end else begin
            state_q     <= S_PLAY;
            music_scale <= drive_code(rom_note);
            o_busy      <= 1'b1;
            o_done      <= 1'b0;
         end
      end else begin
         case (state_q)
            S_PLAY: begin
               end_q <= (idx_q == 5'd31) || (rom_note == END_MARK);
               if (cnt_q == play_last_d) begin
                  state_q     <= S_GAP;
                  cnt_q       <= '0;
                  music_scale <= REST;
               end else begin
                  cnt_q <= cnt_q + cnt_t'(1);
               end
            end
            S_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  cnt_q <= '0;
                  if (end_q && !i_loop) begin
                     state_q <= S_DONE;
                     o_busy  <= 1'b0;
                     o_done  <= 1'b1;
                  end else begin
                     state_q     <= S_PLAY;
                     idx_q       <= end_q ? 5'd0 : idx_inc_d;
                     o_note_idx  <= end_q ? 5'd0 : idx_inc_d;
                     end_q       <= 1'b0;
                     dur_q       <= rom_dur;
                     music_scale <= drive_code(rom_note);
                  end
               end else begin
                  cnt_q <= cnt_q + cnt_t'(1);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               o_done  <= 1'b0;
            end
            default: begin
               o_done <= 1'b0;
            end
         endcase
      end
   end

endmodule
